// File: rtl/riscv_rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_rf_pkg
//  Description : Shared constants and types for the integer register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_rf_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage
`default_nettype wire

// File: rtl/riscv_rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_rf_scoreboard
//  Description : Per-register pending-write bits with hazard lookups that
//                mask a write retiring in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_rf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_valid,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_valid,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy
);
    import riscv_rf_pkg::*;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_clr_live;

    assign w_clr_live = clr_valid && (clr_addr != AW'(ZERO_REG));

    // Set beats clear on the same address: a newer writer is already in flight.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NREG; i++) begin
            if (set_valid && (set_addr == AW'(i)))
                w_busy_nxt[i] = 1'b1;
            else if (w_clr_live && (clr_addr == AW'(i)))
                w_busy_nxt[i] = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign rs1_busy = r_busy[rs1_addr] && !(w_clr_live && (clr_addr == rs1_addr));
    assign rs2_busy = r_busy[rs2_addr] && !(w_clr_live && (clr_addr == rs2_addr));

endmodule
`default_nettype wire

// File: rtl/riscv_regfile_rp2w1.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_regfile_rp2w1
//  Description : 2-read / 1-write integer register file with write-through
//                bypass and pending-write scoreboard. Optional per-entry
//                parity when RF_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_regfile_rp2w1 #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rf_rs1_addr,
    input  logic [AW-1:0]   rf_rs2_addr,
    output logic [XLEN-1:0] rf_rs1_data,
    output logic [XLEN-1:0] rf_rs2_data,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_data,
    input  logic            sb_set_valid,
    input  logic [AW-1:0]   sb_set_addr,
    input  logic [AW-1:0]   sb_rs1_addr,
    input  logic [AW-1:0]   sb_rs2_addr,
    output logic            sb_rs1_busy,
    output logic            sb_rs2_busy,
    output logic            rf_parity_err
);
    import riscv_rf_pkg::*;

    logic [XLEN-1:0] r_mem [NREG];
    logic            w_wr_en;
    logic            w_rs1_zero;
    logic            w_rs2_zero;
    logic            w_rs1_byp;
    logic            w_rs2_byp;

    assign w_wr_en    = wb_we && (wb_rd_addr != AW'(ZERO_REG));
    assign w_rs1_zero = (rf_rs1_addr == AW'(ZERO_REG));
    assign w_rs2_zero = (rf_rs2_addr == AW'(ZERO_REG));
    assign w_rs1_byp  = w_wr_en && (wb_rd_addr == rf_rs1_addr);
    assign w_rs2_byp  = w_wr_en && (wb_rd_addr == rf_rs2_addr);

    // Data path storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[wb_rd_addr] <= wb_rd_data;
    end

    always_comb begin
        rf_rs1_data = r_mem[rf_rs1_addr];
        if (w_rs1_zero)
            rf_rs1_data = '0;
        else if (w_rs1_byp)
            rf_rs1_data = wb_rd_data;

        rf_rs2_data = r_mem[rf_rs2_addr];
        if (w_rs2_zero)
            rf_rs2_data = '0;
        else if (w_rs2_byp)
            rf_rs2_data = wb_rd_data;
    end

    riscv_rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (sb_set_valid),
        .set_addr  (sb_set_addr),
        .clr_valid (wb_we),
        .clr_addr  (wb_rd_addr),
        .rs1_addr  (sb_rs1_addr),
        .rs2_addr  (sb_rs2_addr),
        .rs1_busy  (sb_rs1_busy),
        .rs2_busy  (sb_rs2_busy)
    );

`ifdef RF_PARITY_EN
    logic r_par [NREG];
    logic r_parity_err;
    logic w_rs1_perr;
    logic w_rs2_perr;

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_par[wb_rd_addr] <= ^wb_rd_data;
    end

    // Only array reads are checked; bypassed and x0 values never touch storage.
    assign w_rs1_perr = !w_rs1_zero && !w_rs1_byp &&
                        ((^r_mem[rf_rs1_addr]) != r_par[rf_rs1_addr]);
    assign w_rs2_perr = !w_rs2_zero && !w_rs2_byp &&
                        ((^r_mem[rf_rs2_addr]) != r_par[rf_rs2_addr]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_parity_err <= 1'b0;
        else if (w_rs1_perr || w_rs2_perr)
            r_parity_err <= 1'b1;
    end

    assign rf_parity_err = r_parity_err;
`else
    assign rf_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_regfile_rp2w1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_regfile_rp2w1
//  Description : Directed self-checking bench for riscv_regfile_rp2w1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_regfile_rp2w1;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   rf_rs1_addr, rf_rs2_addr;
    logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
    logic            wb_we;
    logic [AW-1:0]   wb_rd_addr;
    logic [XLEN-1:0] wb_rd_data;
    logic            sb_set_valid;
    logic [AW-1:0]   sb_set_addr, sb_rs1_addr, sb_rs2_addr;
    logic            sb_rs1_busy, sb_rs2_busy;
    logic            rf_parity_err;

    riscv_regfile_rp2w1 #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .rf_rs1_addr   (rf_rs1_addr),
        .rf_rs2_addr   (rf_rs2_addr),
        .rf_rs1_data   (rf_rs1_data),
        .rf_rs2_data   (rf_rs2_data),
        .wb_we         (wb_we),
        .wb_rd_addr    (wb_rd_addr),
        .wb_rd_data    (wb_rd_data),
        .sb_set_valid  (sb_set_valid),
        .sb_set_addr   (sb_set_addr),
        .sb_rs1_addr   (sb_rs1_addr),
        .sb_rs2_addr   (sb_rs2_addr),
        .sb_rs1_busy   (sb_rs1_busy),
        .sb_rs2_busy   (sb_rs2_busy),
        .rf_parity_err (rf_parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        q_exp.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (q_exp.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%h required=<queued value>", obs);
        end else begin
            e = q_exp.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Advance past the next rising edge; inputs change here, samples 3ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] model [32];

    initial begin
        rst          = 1'b1;
        rf_rs1_addr  = '0;
        rf_rs2_addr  = '0;
        wb_we        = 1'b0;
        wb_rd_addr   = '0;
        wb_rd_data   = '0;
        sb_set_valid = 1'b0;
        sb_set_addr  = '0;
        sb_rs1_addr  = 5'd5;
        sb_rs2_addr  = 5'd9;

        // Reset state
        #2;
        push("reset_busy1", 32'd0);   chk(32'(sb_rs1_busy));
        push("reset_busy2", 32'd0);   chk(32'(sb_rs2_busy));
        push("reset_perr", 32'd0);    chk(32'(rf_parity_err));

        // Write x5 while reset is asserted; storage ignores rst
        wb_we = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 32'hDEADBEEF;
        model[5] = 32'hDEADBEEF;
        tick();
        rst = 1'b0; wb_we = 1'b0; rf_rs1_addr = 5'd5;
        push("read_x5", model[5]);
        #3; chk(rf_rs1_data);

        // Same-cycle bypass on both ports
        tick();
        wb_we = 1'b1; wb_rd_addr = 5'd7; wb_rd_data = 32'h12345678;
        rf_rs1_addr = 5'd7; rf_rs2_addr = 5'd7;
        model[7] = 32'h12345678;
        push("bypass_rs1_x7", 32'h12345678);
        push("bypass_rs2_x7", 32'h12345678);
        #3; chk(rf_rs1_data); chk(rf_rs2_data);
        tick();
        wb_we = 1'b0;
        push("stored_rs1_x7", model[7]);
        push("stored_rs2_x7", model[7]);
        #3; chk(rf_rs1_data); chk(rf_rs2_data);

        // x0 writes discarded, x0 reads zero, x0 never busy
        tick();
        wb_we = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 32'hFFFFFFFF;
        rf_rs1_addr = 5'd0; rf_rs2_addr = 5'd5;
        sb_set_valid = 1'b1; sb_set_addr = 5'd0; sb_rs1_addr = 5'd0;
        push("x0_no_bypass", 32'd0);
        push("rs2_x5_unaffected", model[5]);
        #3; chk(rf_rs1_data); chk(rf_rs2_data);
        tick();
        wb_we = 1'b0; sb_set_valid = 1'b0;
        push("x0_read", 32'd0);
        push("x0_busy", 32'd0);
        #3; chk(rf_rs1_data); chk(32'(sb_rs1_busy));

        // Scoreboard set / retire / simultaneous set+retire on x9
        tick();
        sb_set_valid = 1'b1; sb_set_addr = 5'd9;
        tick();
        sb_set_valid = 1'b0; sb_rs1_addr = 5'd9; sb_rs2_addr = 5'd9;
        push("x9_busy1", 32'd1);
        push("x9_busy2", 32'd1);
        #3; chk(32'(sb_rs1_busy)); chk(32'(sb_rs2_busy));
        tick();
        wb_we = 1'b1; wb_rd_addr = 5'd9; wb_rd_data = 32'hCAFEF00D;
        model[9] = 32'hCAFEF00D;
        push("x9_retire_busy1", 32'd0);
        push("x9_retire_busy2", 32'd0);
        #3; chk(32'(sb_rs1_busy)); chk(32'(sb_rs2_busy));
        tick();
        wb_we = 1'b0;
        push("x9_after_retire", 32'd0);
        #3; chk(32'(sb_rs1_busy));
        tick();
        sb_set_valid = 1'b1; sb_set_addr = 5'd9;
        wb_we = 1'b1; wb_rd_addr = 5'd9; wb_rd_data = 32'h0BADC0DE;
        model[9] = 32'h0BADC0DE;
        tick();
        sb_set_valid = 1'b0; wb_we = 1'b0; rf_rs2_addr = 5'd9;
        push("x9_set_wins", 32'd1);
        push("x9_data", model[9]);
        #3; chk(32'(sb_rs1_busy)); chk(rf_rs2_data);

        // Different-address set and clear both apply; then async reset
        tick();
        wb_we = 1'b1; wb_rd_addr = 5'd9; wb_rd_data = model[9];
        sb_set_valid = 1'b1; sb_set_addr = 5'd4;
        tick();
        wb_rd_addr = 5'd3; wb_rd_data = 32'hA5A50003; model[3] = 32'hA5A50003;
        sb_set_addr = 5'd3;
        tick();
        wb_we = 1'b0; sb_set_valid = 1'b0;
        sb_rs1_addr = 5'd3; sb_rs2_addr = 5'd4;
        push("x3_busy", 32'd1);
        push("x4_busy", 32'd1);
        #3; chk(32'(sb_rs1_busy)); chk(32'(sb_rs2_busy));
        sb_rs1_addr = 5'd9;
        push("x9_cleared_other_set", 32'd0);
        #1; chk(32'(sb_rs1_busy));
        sb_rs1_addr = 5'd3;
        rst = 1'b1;
        push("rst_async_x3", 32'd0);
        push("rst_async_x4", 32'd0);
        #1; chk(32'(sb_rs1_busy)); chk(32'(sb_rs2_busy));
        tick();
        rst = 1'b0; rf_rs1_addr = 5'd3;
        push("x3_survives_rst", model[3]);
        push("x4_busy_after_rst", 32'd0);
        #3; chk(rf_rs1_data); chk(32'(sb_rs2_busy));

        // Write a handful of random registers and read them back
        for (int i = 0; i < 6; i++) begin
            tick();
            wb_we = 1'b1; wb_rd_addr = AW'(11 + i); wb_rd_data = $urandom;
            model[11 + i] = wb_rd_data;
        end
        tick();
        wb_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rf_rs1_addr = AW'(11 + i); rf_rs2_addr = AW'(16 - i);
            push("rand_rs1", model[11 + i]);
            push("rand_rs2", model[16 - i]);
            #3; chk(rf_rs1_data); chk(rf_rs2_data);
            tick();
        end

`ifdef RF_PARITY_EN
        wb_we = 1'b1; wb_rd_addr = 5'd10; wb_rd_data = 32'h1; model[10] = 32'h1;
        tick();
        wb_we = 1'b0;
        dut.r_mem[10][4] = ~dut.r_mem[10][4];
        rf_rs1_addr = 5'd10; rf_rs2_addr = 5'd0;
        tick();
        rf_rs1_addr = 5'd0;
        push("parity_flag", 32'd1);
        #3; chk(32'(rf_parity_err));
        wb_we = 1'b1; wb_rd_addr = 5'd10; wb_rd_data = 32'h3; rf_rs2_addr = 5'd10;
        tick();
        wb_we = 1'b0; rf_rs2_addr = 5'd0;
        push("parity_sticky", 32'd1);
        #3; chk(32'(rf_parity_err));
`else
        push("parity_tied_off", 32'd0);
        #3; chk(32'(rf_parity_err));
`endif

        n_tests++;
        assert (q_exp.size() === 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d required=0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_regfile_rp2w1.md
Name: riscv_regfile_rp2w1

Overview:
- Integer register file: the responder for the EX1 read interface (rf_rs1_addr/rf_rs2_addr out, rf_rs1_data/rf_rs2_data in).
- Two combinational read ports and one write port driven by the writeback stage.
- Write-through bypass to both read ports in the write cycle.
- Per-register pending-write scoreboard so ID can detect RAW hazards against in-flight destinations.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; x0 is hardwired zero.
- AW, 5, address width; must equal clog2(NREG).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rf_rs1_addr  input  AW  read port 1 address, driven by EX1.
- rf_rs2_addr  input  AW  read port 2 address, driven by EX1.
- rf_rs1_data  output  XLEN  read port 1 data, combinational.
- rf_rs2_data  output  XLEN  read port 2 data, combinational.
- wb_we  input  1  writeback write enable; qualified by the wb valid upstream.
- wb_rd_addr  input  AW  writeback destination.
- wb_rd_data  input  XLEN  writeback data.
- sb_set_valid  input  1  ID issued an instruction that writes a register.
- sb_set_addr  input  AW  destination of the issued instruction.
- sb_rs1_addr  input  AW  ID hazard-check source 1.
- sb_rs2_addr  input  AW  ID hazard-check source 2.
- sb_rs1_busy  output  1  source 1 has a pending write, combinational.
- sb_rs2_busy  output  1  source 2 has a pending write, combinational.
- rf_parity_err  output  1  registered parity error flag; only meaningful with RF_PARITY_EN.

Behaviour:
- Storage array has NO reset (data path); contents after reset are X until written.
- Scoreboard bits (NREG flops) reset to 0 asynchronously on rst.
- Write: on posedge clk with wb_we=1 and wb_rd_addr!=0, mem[wb_rd_addr] <= wb_rd_data. Writes to x0 are discarded.
- Read: rf_rsN_data = 0 if rf_rsN_addr==0.
  - Otherwise, if wb_we=1 and wb_rd_addr==rf_rsN_addr, it is wb_rd_data (same-cycle bypass).
  - Otherwise it is mem[rf_rsN_addr].
  - Zero latency; EX1 samples the value at the next edge.
- Both read ports may address the same register; each resolves independently.
- Scoreboard update per edge, for address a != 0:
  - set if sb_set_valid && sb_set_addr==a;
  - else clear if wb_we && wb_rd_addr==a;
  - else hold.
  - Simultaneous set and clear of the same address: set wins (a newer writer is in flight).
  - Set and clear of different addresses both take effect.
- x0 scoreboard bit is constant 0; set/clear to x0 are ignored.
- sb_rsN_busy = scoreboard[sb_rsN_addr] && !(wb_we && wb_rd_addr==sb_rsN_addr && wb_rd_addr!=0).
  - A retiring write is not a hazard because the bypass covers it.
- Reset mid-operation: the scoreboard clears immediately; a write coincident with rst deasserted at the edge proceeds normally.
  - Storage is unaffected by rst.
- rf_parity_err resets to 0.

Optional Feature:
- RF_PARITY_EN defined:
  - each entry stores an extra even-parity bit computed from wb_rd_data on write;
  - each read port recomputes parity on non-bypassed, non-x0 reads;
  - rf_parity_err <= OR of both port mismatches on the next edge, sticky until rst.
  - Bypassed and x0 reads never flag.
  - Reads of a never-written entry may flag; the bench masks those.
- RF_PARITY_EN not defined: no parity storage; rf_parity_err tied to 0.

Decomposition:
- Package riscv_rf_pkg: XLEN, NREG, REG_AW constants; reg_addr_t and xlen_t typedefs; ZERO_REG constant.
- One sub-module, riscv_rf_scoreboard: NREG busy bits, set/clear priority, the two busy lookups and the bypass-mask logic.
- The top holds the array, bypass muxes and optional parity.

Test Plan:
- Assert rst, write x5=0xDEADBEEF, read x5 on the next cycle -> rf_rs1_data=0xDEADBEEF.
- wb_we=1, wb_rd_addr=7, wb_rd_data=0x12345678 while rf_rs1_addr=rf_rs2_addr=7 in the same cycle -> both read 0x12345678 combinationally.
- Write x0=0xFFFFFFFF, read x0 -> 0. sb_set_valid with sb_set_addr=0 -> sb_rs1_busy stays 0 for sb_rs1_addr=0.
- sb_set x9, then query sb_rs1_addr=9 -> busy=1.
  - wb_we to x9 -> busy=0 in the retire cycle and after.
  - Set x9 and write x9 in the same cycle -> busy=1 afterwards.
- Set x3 and x4 busy, assert rst for one cycle mid-stream -> both busy=0 immediately.
  - Previously written x3 value is still readable after reset.
- RF_PARITY_EN: write x10=0x1, force-flip a stored bit, read x10 -> rf_parity_err=1 on the next edge and sticky.
  - Bypassed read of x10 -> no additional flag.
